// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: opcode handshake, memory operand and ALU/register-file control bundle
interface alu_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       mem_req;
  logic       mem_ack;
  logic [2:0] reg_sel;
  logic       reg_oe;
  logic       reg_we;
  logic       acc_oe;
  logic       tmp_we;
  logic       a_we;
  logic       a_store;
  logic       a_restore;
  logic       cs;
  logic [4:0] op;
  logic       done;
  logic       illegal;
  modport master (
    input  instr_valid, instr, mem_ack,
    output instr_ready, mem_req, reg_sel, reg_oe, reg_we, acc_oe, tmp_we,
           a_we, a_store, a_restore, cs, op, done, illegal
  );
  modport slave (
    output instr_valid, instr, mem_ack,
    input  instr_ready, mem_req, reg_sel, reg_oe, reg_we, acc_oe, tmp_we,
           a_we, a_store, a_restore, cs, op, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives SAP-3 ALU controls from an 8080 opcode; ALU_SEQ_REGOPS_EN adds INR r/DCR r
module alu_sequencer (
  input logic             clk,
  input logic             rst,
  alu_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_TMP, S_WAIT_MEM, S_EXEC, S_SETTLE, S_FINISH
`ifdef ALU_SEQ_REGOPS_EN
    , S_SAVE, S_LOAD_A, S_WRITE, S_RESTORE
`endif
  } state_t;
  typedef enum logic [2:0] {C_REG, C_MEM, C_ACC, C_RMW, C_ILL} cls_t;
  state_t     r_state, w_next;
  logic [7:0] r_instr, w_opc;
  logic [4:0] r_op, w_op;
  cls_t       w_cls;
  logic       w_ld_acc, w_rmw_bus;
  logic [2:0] w_reg_sel;
  function automatic cls_t f_cls(input logic [7:0] b);
    if (b[7:6] == 2'b10) begin
      if (b[2:0] == 3'd6) return C_MEM;
      return C_REG;
    end
    if (b[7:6] == 2'b11 && b[2:0] == 3'd6) return C_MEM;
    if (b[7:6] == 2'b00 && b[2:0] == 3'd7 && b[5:3] != 3'd4) return C_ACC;
    if (b == 8'h3C || b == 8'h3D) return C_ACC;
`ifdef ALU_SEQ_REGOPS_EN
    if (b[7:6] == 2'b00 && b[2:1] == 2'b10 && b[5:3] <= 3'd5) return C_RMW;
`else
    if (b[7:6] == 2'b00 && b[2:1] == 2'b10 && b[5:3] <= 3'd5) return C_ILL;
`endif
    return C_ILL;
  endfunction
  // Decode the offered opcode while idle, the latched one afterwards.
  assign w_opc = (r_state == S_IDLE) ? bus.instr : r_instr;
  assign w_cls = f_cls(w_opc);
  assign w_op  = w_opc[7] ? {2'b00, w_opc[5:3]} :
                 (w_opc[2:0] == 3'd7) ? {2'b01, w_opc[5:3]} : {4'b1000, w_opc[0]};
  // State, latched opcode and op register; op only changes on entry to EXEC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.instr_valid) r_instr <= bus.instr;
      if (w_next == S_EXEC && r_state != S_EXEC) r_op <= w_op;
    end
  end
  // Next-state sequencing per opcode class.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (bus.instr_valid)
          case (w_cls)
            C_REG:   w_next = S_LOAD_TMP;
            C_MEM:   w_next = S_WAIT_MEM;
            C_ACC:   w_next = S_EXEC;
`ifdef ALU_SEQ_REGOPS_EN
            C_RMW:   w_next = S_SAVE;
`endif
            default: w_next = S_FINISH;
          endcase
      S_LOAD_TMP: w_next = S_EXEC;
      S_WAIT_MEM: if (bus.mem_ack) w_next = S_EXEC;
`ifdef ALU_SEQ_REGOPS_EN
      S_EXEC:     if (w_cls == C_RMW) w_next = S_WRITE; else w_next = S_SETTLE;
      S_SAVE:     w_next = S_LOAD_A;
      S_LOAD_A:   w_next = S_EXEC;
      S_WRITE:    w_next = S_RESTORE;
`else
      S_EXEC:     w_next = S_SETTLE;
`endif
      default:    w_next = S_IDLE;
    endcase
  end
  // Bus-source selection; the accumulator source uses r=7, INR/DCR r addresses bits 5:3.
  assign w_ld_acc  = r_state == S_LOAD_TMP && r_instr[2:0] == 3'd7;
`ifdef ALU_SEQ_REGOPS_EN
  assign w_rmw_bus = r_state == S_LOAD_A || r_state == S_WRITE;
`else
  assign w_rmw_bus = 1'b0;
`endif
  assign w_reg_sel = (r_state == S_LOAD_TMP && !w_ld_acc) ? r_instr[2:0] :
                     w_rmw_bus ? r_instr[5:3] : 3'd0;
  assign bus.instr_ready = rst && r_state == S_IDLE;
  assign bus.mem_req     = rst && r_state == S_WAIT_MEM;
  assign bus.tmp_we      = rst && (r_state == S_LOAD_TMP || (r_state == S_WAIT_MEM && bus.mem_ack));
  assign bus.cs          = rst && r_state == S_EXEC;
  assign bus.op          = r_op;
  assign bus.reg_sel     = rst ? w_reg_sel : 3'd0;
  assign bus.illegal     = rst && r_state == S_FINISH;
`ifdef ALU_SEQ_REGOPS_EN
  assign bus.reg_oe      = rst && ((r_state == S_LOAD_TMP && !w_ld_acc) || r_state == S_LOAD_A);
  assign bus.acc_oe      = rst && (w_ld_acc || r_state == S_WRITE);
  assign bus.reg_we      = rst && r_state == S_WRITE;
  assign bus.a_we        = rst && r_state == S_LOAD_A;
  assign bus.a_store     = rst && r_state == S_SAVE;
  assign bus.a_restore   = rst && r_state == S_RESTORE;
  assign bus.done        = rst && (r_state == S_SETTLE || r_state == S_FINISH || r_state == S_RESTORE);
`else
  assign bus.reg_oe      = rst && r_state == S_LOAD_TMP && !w_ld_acc;
  assign bus.acc_oe      = rst && w_ld_acc;
  assign bus.reg_we      = 1'b0;
  assign bus.a_we        = 1'b0;
  assign bus.a_store     = 1'b0;
  assign bus.a_restore   = 1'b0;
  assign bus.done        = rst && (r_state == S_SETTLE || r_state == S_FINISH);
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with random opcodes and memory delays
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master));
  typedef struct {
    int ill, op, lat, cs, roe, aoe, tmp, mem, rwe, awe, ast, ares, sel, t0;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int tests = 0, fails = 0, cyc = 0;
  int n_cs, n_roe, n_aoe, n_tmp, n_mem, n_rwe, n_awe, n_ast, n_ares, seen_op, seen_sel;
  bit prev_done;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask
  function automatic int outs();
    return int'({bus.instr_ready, bus.mem_req, bus.reg_sel, bus.reg_oe, bus.reg_we, bus.acc_oe,
                 bus.tmp_we, bus.a_we, bus.a_store, bus.a_restore, bus.cs, bus.op, bus.done,
                 bus.illegal});
  endfunction
  // Reference: classify the opcode by its 8080 table position and derive the expected activity.
  function automatic exp_t model(input int o, input int d);
    exp_t e = '{default: 0};
    int k = o / 8;
    int s = o % 8;
    e.ill = 1;
    e.lat = 1;
    if ((o >= 'h80 && o <= 'hBF) || (o >= 'hC0 && s == 6)) begin
      e.ill = 0; e.op = k % 8; e.cs = 1; e.tmp = 1; e.lat = 3;
      if (s == 6) begin e.lat = 3 + d; e.mem = 1 + d; end
      else if (s == 7) e.aoe = 1;
      else begin e.roe = 1; e.sel = s; end
    end else if (o < 'h40 && s == 7 && o != 'h27) begin
      e.ill = 0; e.op = 8 + k; e.cs = 1; e.lat = 2;
    end else if (o == 'h3C || o == 'h3D) begin
      e.ill = 0; e.op = 16 + o % 2; e.cs = 1; e.lat = 2;
    end
`ifdef ALU_SEQ_REGOPS_EN
    else if (o < 'h30 && (s == 4 || s == 5)) begin
      e.ill = 0; e.op = 16 + o % 2; e.cs = 1; e.lat = 5; e.sel = k;
      e.ast = 1; e.roe = 1; e.awe = 1; e.aoe = 1; e.rwe = 1; e.ares = 1;
    end
`endif
    return e;
  endfunction
  task automatic clr();
    n_cs = 0; n_roe = 0; n_aoe = 0; n_tmp = 0; n_mem = 0; n_rwe = 0; n_awe = 0;
    n_ast = 0; n_ares = 0; seen_op = -1; seen_sel = -1;
  endtask
  // Monitor: accumulate per-transaction activity, compare against the scoreboard on each done.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      clr();
      prev_done = 0;
      chk("done_in_reset", int'(bus.done), 0);
    end else begin
      if (prev_done) chk("ready_after_done", int'(bus.instr_ready), 1);
      prev_done = bus.done;
      chk("bus_exclusive", int'(int'(bus.reg_oe) + int'(bus.acc_oe) + int'(bus.mem_req & bus.mem_ack) <= 1), 1);
      chk("illegal_without_done", int'(bus.illegal & ~bus.done), 0);
      n_cs += int'(bus.cs); n_roe += int'(bus.reg_oe); n_aoe += int'(bus.acc_oe);
      n_tmp += int'(bus.tmp_we); n_mem += int'(bus.mem_req); n_rwe += int'(bus.reg_we);
      n_awe += int'(bus.a_we); n_ast += int'(bus.a_store); n_ares += int'(bus.a_restore);
      if (bus.cs) seen_op = int'(bus.op);
      if (bus.reg_oe) seen_sel = int'(bus.reg_sel);
      if (bus.done) begin
        chk("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          m_e = sb.pop_front();
          chk("illegal", int'(bus.illegal), m_e.ill);
          chk("latency", cyc - m_e.t0, m_e.lat);
          chk("cs_cycles", n_cs, m_e.cs);
          if (m_e.cs != 0) chk("op", seen_op, m_e.op);
          chk("reg_oe_cycles", n_roe, m_e.roe);
          if (m_e.roe != 0) chk("reg_sel", seen_sel, m_e.sel);
          chk("acc_oe_cycles", n_aoe, m_e.aoe);
          chk("tmp_we_cycles", n_tmp, m_e.tmp);
          chk("mem_req_cycles", n_mem, m_e.mem);
          chk("reg_we_cycles", n_rwe, m_e.rwe);
          chk("a_we_cycles", n_awe, m_e.awe);
          chk("a_store_cycles", n_ast, m_e.ast);
          chk("a_restore_cycles", n_ares, m_e.ares);
        end
        clr();
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(bus.instr_ready), 1);
  endtask
  task automatic issue(input int o, input int d);
    exp_t e;
    wait_ready();
    if (!bus.instr_ready) return;
    e = model(o, d);
    e.t0 = cyc;
    sb.push_back(e);
    bus.instr_valid = 1'b1;
    bus.instr = o[7:0];
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = 8'($urandom);
    if (e.mem != 0) begin
      for (int i = 0; i <= d; i++) begin
        bus.mem_ack = (i == d);
        @(posedge clk);
        #1;
      end
      bus.mem_ack = 1'b0;
    end
  endtask
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    issue('h80, 0);
    issue('hCE, 3);
    issue('h17, 0);
    issue('h0C, 0);
    issue('h27, 0);
    issue('h34, 0);
    issue('h87, 0);
    issue('h86, 2);
    issue('h3D, 0);
    issue('h2D, 0);
    issue('hFE, 0);
    issue('h00, 0);
    wait_ready();
    bus.instr_valid = 1'b1;
    bus.instr = 8'hCE;
    m_e = model('hCE, 0);
    m_e.t0 = cyc;
    sb.push_back(m_e);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("mem_req_pending", int'(bus.mem_req), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.instr_ready), 1);
    issue('hB8, 0);
    repeat (300) issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
    for (int n = 0; n < 50 && sb.size() > 0; n++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control sequencer that drives the SAP-3 accumulator ALU's control inputs from an 8080-style opcode. It accepts one opcode per valid/ready handshake and moves operands onto the shared 8-bit bus from the register file, the accumulator or memory. It then issues one ALU operation and signals completion once the flags have settled. It sits between the instruction decoder/fetch unit and the ALU/register file.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `instr_valid`  in  1  opcode offered.
- `instr`  in  8  opcode; sampled only in the acceptance cycle.
- `instr_ready`  out  1  high only in IDLE with rst high.
- `mem_req`  out  1  operand byte request (M source or immediate).
- `mem_ack`  in  1  memory drives the bus this cycle.
- `reg_sel`  out  3  register-file index (0=B … 5=L).
- `reg_oe`  out  1  register file drives the bus.
- `reg_we`  out  1  register file captures the bus.
- `acc_oe`  out  1  accumulator drives the bus.
- `tmp_we`, `a_we`, `a_store`, `a_restore`, `cs`  out  1 each  ALU controls.
- `op`  out  5  ALU operation code.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  qualifies `done`: the opcode was rejected.

## Operation
- States: IDLE, LOAD_TMP, WAIT_MEM, SAVE, LOAD_A, EXEC, WRITE, RESTORE, SETTLE, FINISH.
- Acceptance: `instr_valid` and `instr_ready` both high. The opcode is latched, and later `instr` changes are ignored.
- Decoding of the latched opcode. `r` = opcode[2:0], `k` = opcode[5:3]:
  - 0x80–0xBF (register ALU): `op` = {2'b00,k}.
    - r ≤ 5: LOAD_TMP with `reg_oe`, `tmp_we`, `reg_sel`=r.
    - r = 7: LOAD_TMP with `acc_oe`, `tmp_we`.
    - r = 6: WAIT_MEM.
    - Then EXEC, then SETTLE.
  - 0xC6/CE/D6/DE/E6/EE/F6/FE (immediate): `op` = {2'b00,k}. WAIT_MEM, EXEC, SETTLE.
  - 0x07/0F/17/1F/2F/37/3F (accumulator ops): `op` = {2'b01,k}. EXEC, SETTLE.
  - 0x3C/0x3D (INR A/DCR A): `op` = 5'b10000/5'b10001. EXEC, SETTLE.
  - INR r/DCR r, r ≤ 5 (opcode 00rrr10x): handled per Configuration.
  - Everything else, including 0x27 (DAA) and INR M/DCR M: FINISH with `illegal`=1.
- WAIT_MEM:
  - `mem_req`=1 until `mem_ack`.
  - In the `mem_ack` cycle, `tmp_we`=1 combinationally; next state is EXEC.
  - `mem_req` is 0 from the following cycle.
- EXEC: `cs`=1 and `op` valid for exactly one cycle.
- SETTLE: one idle cycle so the ALU's negative-edge flag update completes. `done`=1 in this cycle; next state is IDLE.
- FINISH: `done`=1 and `illegal`=1; next state is IDLE.
- `op` holds its last value outside EXEC; only `cs` qualifies it.
- Bus exclusivity: at most one of `reg_oe`, `acc_oe`, or (`mem_req` and `mem_ack`) is high in any cycle.
- `illegal` is 0 whenever `done`=0.

## Timing
- Reset: every output 0 (including `instr_ready`, `op`=0), state IDLE, latched opcode 0x00.
- Reset mid-operation: IDLE on the next edge. `mem_req` drops and no `done` is issued. A saved accumulator is not restored; the controller owns recovery.
- Latency counts from the acceptance cycle T0:
  - register source: `done` at T3.
  - accumulator op: `done` at T2.
  - M/immediate: `done` at T3 + (cycles `mem_ack` is late).
  - illegal: `done` at T1.
  - INR/DCR r: `done` at T5.
- Throughput: `instr_ready` returns the cycle after `done`. `instr_valid` during busy or `done` cycles is not accepted.
- `mem_ack` outside WAIT_MEM is ignored.

## Configuration
- `ALU_SEQ_REGOPS_EN` defined, INR r/DCR r with r ≤ 5 runs this sequence:
  - SAVE: `a_store`.
  - LOAD_A: `reg_oe`, `a_we`, `reg_sel`=r.
  - EXEC: `cs`, `op`=INR/DCR.
  - WRITE: `acc_oe`, `reg_we`, `reg_sel`=r.
  - RESTORE: `a_restore`, `done`.
  - The accumulator is unchanged afterwards.
- Undefined: those opcodes go to FINISH with `illegal`=1, and SAVE/LOAD_A/WRITE/RESTORE are not built.

## Test plan
- 0x80 (ADD B) accepted at T0 -> T1 `reg_oe`=`tmp_we`=1, `reg_sel`=0; T2 `cs`=1, `op`=0; T3 `done`=1, `illegal`=0; T4 `instr_ready`=1.
- 0xCE (ACI), `mem_ack` held low 3 cycles then high -> `mem_req` high 4 cycles; `tmp_we` only in the ack cycle; next cycle `cs`=1, `op`=1; `done` two cycles after ack.
- 0x17 (RAL) -> T1 `cs`=1, `op`=5'b01010; T2 `done`; no bus-drive output asserted at any time.
- 0x0C (INR C) with macro -> T1 `a_store`, T2 `reg_oe`+`a_we` with `reg_sel`=1, T3 `cs`/`op`=5'b10000, T4 `acc_oe`+`reg_we`, T5 `a_restore`+`done`. Without the macro -> T1 `done`+`illegal`.
- 0x27 (DAA) and 0x34 (INR M) -> T1 `done`=`illegal`=1; `cs` never asserted.
- `rst` low during WAIT_MEM -> next edge: all outputs 0, no `done`. After `rst` high, `instr_ready`=1 and a new 0xB8 (CMP B) completes normally.
